// File: rtl/vc_locking_rr_arb.sv
// Round-robin arbiter over val/rdy channels that locks the grant for a whole
// multi-beat packet; priority rotates past the winner only when the last beat transfers.
module vc_locking_rr_arb #(
    parameter int unsigned          NUM_REQS           = 4,
    parameter int unsigned          MSG_NBITS          = 32,
    parameter logic [NUM_REQS-1:0]  RESET_PRIORITY_VAL = NUM_REQS'(1),
    localparam int unsigned         SRC_NBITS          = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           in_val,
    output logic [NUM_REQS-1:0]           in_rdy,
    input  logic [NUM_REQS*MSG_NBITS-1:0] in_msg,
    input  logic [NUM_REQS-1:0]           in_last,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [MSG_NBITS-1:0]          out_msg,
    output logic                          out_last,
    output logic [SRC_NBITS-1:0]          out_src,
    output logic                          locked
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e                state_q, state_d;
    logic [NUM_REQS-1:0]   lock_id_q, lock_id_d;
    logic [NUM_REQS-1:0]   prio_q, prio_d;
    logic [NUM_REQS-1:0]   arb_grant, grant;
    logic [2*NUM_REQS-1:0] req_dbl, arb_dbl;
    logic                  xfer;

    function automatic logic [NUM_REQS-1:0] rotl1(input logic [NUM_REQS-1:0] v);
        return {v[NUM_REQS-2:0], v[NUM_REQS-1]};
    endfunction

    // Doubled request vector: the borrow chain of the subtraction finds the first
    // requester at or above the priority bit, wrapping through the upper copy.
    always_comb begin
        req_dbl   = {in_val, in_val};
        arb_dbl   = req_dbl & ~(req_dbl - {{NUM_REQS{1'b0}}, prio_q});
        arb_grant = arb_dbl[NUM_REQS-1:0] | arb_dbl[2*NUM_REQS-1:NUM_REQS];
    end

    always_comb begin
        locked   = (state_q == StLocked);
        grant    = locked ? lock_id_q : arb_grant;
        out_val  = locked ? |(in_val & lock_id_q) : |in_val;
        in_rdy   = grant & {NUM_REQS{out_rdy}};
        out_msg  = '0;
        out_last = 1'b0;
        out_src  = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            out_msg  = out_msg | (in_msg[i*MSG_NBITS +: MSG_NBITS] & {MSG_NBITS{grant[i]}});
            out_last = out_last | (in_last[i] & grant[i]);
            if (grant[i]) out_src = out_src | SRC_NBITS'(i);
        end
    end

    always_comb begin
        xfer      = out_val & out_rdy;
        state_d   = state_q;
        lock_id_d = lock_id_q;
        prio_d    = prio_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    if (out_last) begin
                        prio_d = rotl1(arb_grant);
                    end else begin
                        state_d   = StLocked;
                        lock_id_d = arb_grant;
                    end
                end
            end
            StLocked: begin
                if (xfer && out_last) begin
                    state_d = StIdle;
                    prio_d  = rotl1(lock_id_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            lock_id_q <= '0;
            prio_q    <= RESET_PRIORITY_VAL;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            prio_q    <= prio_d;
        end
    end

    assert property (@(posedge clk) disable iff (reset) $onehot(prio_q));
    assert property (@(posedge clk) disable iff (reset) locked |-> $onehot(lock_id_q));
    assert property (@(posedge clk) disable iff (reset) $onehot0(in_rdy));
    // A stalled beat of the locked requester must be presented unchanged.
    assert property (@(posedge clk) disable iff (reset)
        (locked && out_val && !out_rdy) |=> ($stable(out_msg) && $stable(out_last)));

endmodule
